// File: rtl/fifo_read_streamer.sv
// Read-side consumer of an async FIFO: prefetches into a 2-entry buffer, presents the
// words as a valid/ready stream framed into bursts, and counts delivered beats.
module fifo_read_streamer #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 32
) (
  input  logic              r_clk,
  input  logic              r_reset_n,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_r_data,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [1:0]        count_q, count_d;
  logic              rdPend_q;
  logic              drop_q;
  logic              run_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0]  wordCnt_q;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic       pop;
  logic       capture;
  logic [2:0] inFlight;
  logic [2:0] countNext;

  assign pop      = m_valid & m_ready;
  assign m_valid  = (count_q != 2'd0);
  assign m_data   = head_q;
  assign m_last   = m_valid & (beat_q == LAST_BEAT);
  assign word_cnt = wordCnt_q;
  assign capture  = rdPend_q & ~drop_q;

  // Buffered words plus the read already in flight, after this cycle's pop, must leave a free slot.
  assign inFlight  = {1'b0, count_q} + {2'b0, rdPend_q} - {2'b0, pop};
  assign fifo_r_en = run_q & ~fifo_empty & ~flush & (inFlight < 3'd2);
  assign countNext = {1'b0, count_q} + {2'b0, capture} - {2'b0, pop};

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = flush ? 2'd0 : countNext[1:0];
    beat_d  = beat_q;
    if (pop && (count_q == 2'd2)) begin
      head_d = tail_q;
    end
    // The arriving word lands in whichever slot is free once this cycle's pop has left.
    if (capture) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        head_d = fifo_r_data;
      end else begin
        tail_d = fifo_r_data;
      end
    end
    if (flush) begin
      beat_d = '0;
    end else if (pop) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge r_clk or negedge r_reset_n) begin
    if (!r_reset_n) begin
      run_q     <= 1'b0;
      count_q   <= 2'd0;
      rdPend_q  <= 1'b0;
      drop_q    <= 1'b0;
      beat_q    <= '0;
      wordCnt_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      run_q    <= 1'b1;
      count_q  <= count_d;
      rdPend_q <= fifo_r_en;
      drop_q   <= flush & rdPend_q;
      beat_q   <= beat_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      if (pop) begin
        wordCnt_q <= wordCnt_q + CNT_W'(1);
      end
    end
  end

  overflowCheck: assert property (@(posedge r_clk) disable iff (!r_reset_n) countNext <= 3'd2);

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Directed and randomised bench for fifo_read_streamer; the FIFO read port is modelled
// with a queue and a one-cycle read latency, delivered beats are scoreboarded in order.
module tb_fifo_read_streamer;

  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 8;
  localparam int CNT_W     = 32;

  logic              r_clk = 1'b0;
  logic              r_reset_n;
  logic              flush;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_r_data;
  logic              fifo_r_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic [CNT_W-1:0]  word_cnt;

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] fifoQ[$];
  logic [DATA_W-1:0] expQ[$];
  logic              holdEmpty;
  int                tbBeat;
  logic [CNT_W-1:0]  tbCnt;

  logic              sREn, sValid, sLast;
  logic [DATA_W-1:0] sData;
  logic              prevHold, prevLast;
  logic [DATA_W-1:0] prevData;

  fifo_read_streamer #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
  ) dut (
    .r_clk(r_clk), .r_reset_n(r_reset_n), .flush(flush),
    .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data), .fifo_r_en(fifo_r_en),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .word_cnt(word_cnt)
  );

  always #5 r_clk = ~r_clk;

  // One clock cycle, entered and left on the falling edge; inputs are set by the caller beforehand.
  task automatic step();
    logic [DATA_W-1:0] expData;
    logic [DATA_W-1:0] rdWord;
    logic              expLast;
    rdWord = '0;
    fifo_empty = holdEmpty || (fifoQ.size() == 0);
    #1;
    sREn = fifo_r_en; sValid = m_valid; sData = m_data; sLast = m_last;
    checks++;
    if (sREn && fifo_empty) begin
      failures++;
      $display("[TB] FAIL underflow_read: fifo_r_en=%0b while fifo_empty=%0b, required fifo_r_en=0", sREn, fifo_empty);
    end
    checks++;
    if (!sValid && sLast !== 1'b0) begin
      failures++;
      $display("[TB] FAIL last_without_valid: m_last=%0b, required 0", sLast);
    end
    if (prevHold) begin
      checks++;
      if (sValid !== 1'b1 || sData !== prevData || sLast !== prevLast) begin
        failures++;
        $display("[TB] FAIL handshake_hold: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                 sValid, sData, sLast, prevData, prevLast);
      end
    end
    if (sValid && m_ready) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_beat: data=%h delivered, required no beat", sData);
      end else begin
        expData = expQ.pop_front();
        expLast = (tbBeat == BURST_LEN - 1);
        if (sData !== expData || sLast !== expLast) begin
          failures++;
          $display("[TB] FAIL beat_data: data=%h last=%0b, required data=%h last=%0b", sData, sLast, expData, expLast);
        end
      end
      tbCnt  = tbCnt + 1;
      tbBeat = (tbBeat == BURST_LEN - 1) ? 0 : tbBeat + 1;
    end
    prevHold = sValid && !m_ready && !flush;
    prevData = sData;
    prevLast = sLast;
    if (flush) begin
      expQ.delete();
      tbBeat = 0;
    end
    if (sREn && fifoQ.size() != 0) begin
      rdWord = fifoQ.pop_front();
      expQ.push_back(rdWord);
    end
    checks++;
    if (expQ.size() > 2) begin
      failures++;
      $display("[TB] FAIL occupancy: %0d words read but undelivered, required at most 2", expQ.size());
    end
    @(posedge r_clk);
    #1;
    fifo_r_data = sREn ? rdWord : DATA_W'($urandom);
    @(negedge r_clk);
  endtask

  task automatic test_reset();
    r_reset_n = 1'b1;
    #1 r_reset_n = 1'b0;
    fifo_empty = 1'b0;
    #2;
    checks++;
    if ({fifo_r_en, m_valid, m_last} !== 3'b000 || m_data !== '0 || word_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: r_en=%0b valid=%0b last=%0b data=%h cnt=%0d, required all 0",
               fifo_r_en, m_valid, m_last, m_data, word_cnt);
    end
    @(negedge r_clk);
    @(negedge r_clk);
    r_reset_n = 1'b1;
    #1;
    checks++;
    if (fifo_r_en !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_hold: r_en=%0b valid=%0b before first edge, required 0 0", fifo_r_en, m_valid);
    end
    fifo_empty = 1'b1;
    @(negedge r_clk);
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 20; i++) fifoQ.push_back(DATA_W'(i));
    holdEmpty = 1'b0;
    m_ready   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step();
      if (i <= 1) begin
        checks++;
        if (sValid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL stream_latency: m_valid=%0b at cycle %0d, required 0", sValid, i);
        end
      end
      if (i <= 19) begin
        checks++;
        if (sREn !== 1'b1) begin
          failures++;
          $display("[TB] FAIL stream_r_en: fifo_r_en=%0b at cycle %0d, required 1", sREn, i);
        end
      end
      if (i >= 2 && i <= 21) begin
        checks++;
        if (sValid !== 1'b1 || sData !== DATA_W'(i - 1)) begin
          failures++;
          $display("[TB] FAIL stream_beat: valid=%0b data=%h at cycle %0d, required valid=1 data=%h",
                   sValid, sData, i, DATA_W'(i - 1));
        end
      end
      if (i == 9 || i == 17) begin
        checks++;
        if (sLast !== 1'b1) begin
          failures++;
          $display("[TB] FAIL stream_last: m_last=%0b on beat %0d, required 1", sLast, i - 1);
        end
      end
    end
    checks++;
    if (word_cnt !== 32'd20) begin
      failures++;
      $display("[TB] FAIL stream_word_cnt: word_cnt=%0d, required 20", word_cnt);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 16; i++) fifoQ.push_back(DATA_W'(16'h0100 + i));
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 3) begin
        checks++;
        if (sREn !== 1'b0 || sValid !== 1'b1 || sData !== 16'h0100) begin
          failures++;
          $display("[TB] FAIL backpressure_hold: r_en=%0b valid=%0b data=%h at cycle %0d, required 0 1 0100",
                   sREn, sValid, sData, i);
        end
      end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step();
      if (i < 16) begin
        checks++;
        if (sValid !== 1'b1 || sData !== DATA_W'(16'h0100 + i)) begin
          failures++;
          $display("[TB] FAIL backpressure_release: valid=%0b data=%h at beat %0d, required valid=1 data=%h",
                   sValid, sData, i, DATA_W'(16'h0100 + i));
        end
      end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 12; i++) fifoQ.push_back(DATA_W'(16'h0200 + i));
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    holdEmpty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        checks++;
        if (sREn !== 1'b0) begin
          failures++;
          $display("[TB] FAIL drain_r_en: fifo_r_en=%0b with fifo_empty=1, required 0", sREn);
        end
      end
      if (i == 2 || i == 4) begin
        checks++;
        if (sValid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL drain_valid: m_valid=%0b %0d cycles into empty, required 0", sValid, i);
        end
      end
    end
    holdEmpty = 1'b0;
    for (int i = 0; i < 20 && (fifoQ.size() != 0 || expQ.size() != 0); i++) step();
    checks++;
    if (fifoQ.size() != 0 || expQ.size() != 0 || word_cnt !== 32'd48) begin
      failures++;
      $display("[TB] FAIL drain_resume: %0d+%0d words pending, word_cnt=%0d, required 0+0 and 48",
               fifoQ.size(), expQ.size(), word_cnt);
    end
  endtask

  task automatic test_flush();
    int beats;
    for (int i = 0; i < 12; i++) fifoQ.push_back(DATA_W'(16'h0300 + i));
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (sValid !== 1'b1 || sData !== 16'h0302 || sREn !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_cycle: valid=%0b data=%h r_en=%0b, required 1 0302 0", sValid, sData, sREn);
    end
    step();
    checks++;
    if (sValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_valid_drop: m_valid=%0b after flush, required 0", sValid);
    end
    beats = 0;
    for (int i = 0; i < 16 && beats < 8; i++) begin
      step();
      if (sValid) begin
        beats++;
        if (beats == 1) begin
          checks++;
          if (sData !== 16'h0304) begin
            failures++;
            $display("[TB] FAIL flush_first_beat: data=%h, required 0304", sData);
          end
        end
        if (beats == 8) begin
          checks++;
          if (sLast !== 1'b1 || sData !== 16'h030B) begin
            failures++;
            $display("[TB] FAIL flush_burst_last: last=%0b data=%h, required 1 030b", sLast, sData);
          end
        end
      end
    end
    step();
    checks++;
    if (beats != 8 || word_cnt !== 32'd59) begin
      failures++;
      $display("[TB] FAIL flush_word_cnt: %0d beats after flush, word_cnt=%0d, required 8 and 59", beats, word_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 12; i++) fifoQ.push_back(DATA_W'(16'h0400 + i));
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #2 r_reset_n = 1'b0;
    #1;
    checks++;
    if ({fifo_r_en, m_valid, m_last} !== 3'b000 || m_data !== '0 || word_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL midburst_reset: r_en=%0b valid=%0b last=%0b data=%h cnt=%0d, required all 0",
               fifo_r_en, m_valid, m_last, m_data, word_cnt);
    end
    #1 r_reset_n = 1'b1;
    expQ.delete();
    tbBeat   = 0;
    tbCnt    = '0;
    prevHold = 1'b0;
    @(negedge r_clk);
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin
        checks++;
        if (sREn !== 1'b1 || sValid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL restart_issue: r_en=%0b valid=%0b, required 1 0", sREn, sValid);
        end
      end
      if (i == 2) begin
        checks++;
        if (sValid !== 1'b1 || sData !== 16'h0405) begin
          failures++;
          $display("[TB] FAIL restart_first: valid=%0b data=%h, required 1 0405", sValid, sData);
        end
      end
    end
    for (int i = 0; i < 20 && (fifoQ.size() != 0 || expQ.size() != 0); i++) step();
    checks++;
    if (word_cnt !== 32'd7) begin
      failures++;
      $display("[TB] FAIL restart_word_cnt: word_cnt=%0d, required 7", word_cnt);
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] nextWord;
    nextWord = 16'h1000;
    for (int i = 0; i < 10000; i++) begin
      while (fifoQ.size() < 4) begin
        fifoQ.push_back(nextWord);
        nextWord = nextWord + 1'b1;
      end
      m_ready   = ($urandom_range(0, 3) != 0);
      holdEmpty = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 63) == 0);
      step();
    end
    flush     = 1'b0;
    m_ready   = 1'b1;
    holdEmpty = 1'b0;
    for (int i = 0; i < 40 && (fifoQ.size() != 0 || expQ.size() != 0); i++) step();
    checks++;
    if (fifoQ.size() != 0 || expQ.size() != 0 || word_cnt !== tbCnt) begin
      failures++;
      $display("[TB] FAIL random_drain: %0d+%0d words pending, word_cnt=%0d, required 0+0 and %0d",
               fifoQ.size(), expQ.size(), word_cnt, tbCnt);
    end
  endtask

  initial begin
    flush       = 1'b0;
    m_ready     = 1'b0;
    holdEmpty   = 1'b1;
    fifo_empty  = 1'b1;
    fifo_r_data = '0;
    prevHold    = 1'b0;
    prevData    = '0;
    prevLast    = 1'b0;
    tbBeat      = 0;
    tbCnt       = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_flush();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
